// File: rtl/cordic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_ctrl_pkg
// Brief    : Shared state type, default sizing and config check for the
//            CORDIC sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_IN = 3'd1,
      INIT    = 3'd2,
      ITER    = 3'd3,
      OUT     = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int unsigned c_n_iter_default = 26;
   localparam int unsigned c_cnt_w_default  = 5;

   // True when the counter can reach N_ITER-1 and at least two rotations run.
   function automatic bit cnt_w_ok(input int unsigned n_iter, input int unsigned cnt_w);
      return (n_iter >= 2) && (cnt_w >= 1) && (cnt_w < 32) &&
             ((64'd1 << cnt_w) >= 64'(n_iter));
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_counter
// Brief    : Iteration index counter with sync clear, enable and terminal
//            count at N_ITER-1.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_iter_counter #(
   parameter int unsigned N_ITER = 26,
   parameter int unsigned CNT_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt = r_cnt;
   assign tc  = (r_cnt == CNT_W'(N_ITER - 1));

endmodule
`default_nettype wire

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_seq_ctrl
// Brief    : Sequencing FSM for the iterative CORDIC sin/cos datapath.
//            Define CORDIC_AUTO_ACK_EN to make DONE a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_seq_ctrl
   import cordic_ctrl_pkg::*;
#(
   parameter int unsigned N_ITER = c_n_iter_default,
   parameter int unsigned CNT_W  = c_cnt_w_default
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sel,
   input  logic             ack,
   output logic             ld_in_en,
   output logic             sel_init,
   output logic             ld_iter_en,
   output logic             ld_out_en,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             op_q,
   output logic             busy,
   output logic             ready
);

   if (!cnt_w_ok(N_ITER, CNT_W)) begin : g_cfg_err
      $error("cordic_seq_ctrl: CNT_W too small for N_ITER, or N_ITER < 2");
   end

   state_t r_state;
   state_t w_next_state;
   logic   r_op_q;
   logic   w_tc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_op_q  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE && start) begin
            r_op_q <= op_sel;
         end
      end
   end

   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE:    w_next_state = start ? LOAD_IN : IDLE;
         LOAD_IN: w_next_state = INIT;
         INIT:    w_next_state = ITER;
         ITER:    w_next_state = w_tc ? OUT : ITER;
         OUT:     w_next_state = DONE;
`ifdef CORDIC_AUTO_ACK_EN
         DONE:    w_next_state = IDLE;
`else
         DONE:    w_next_state = ack ? IDLE : DONE;
`endif
         default: w_next_state = IDLE;
      endcase
   end

   // Counter is held clear outside ITER so iter_cnt reads 0 there.
   cordic_iter_counter #(
      .N_ITER (N_ITER),
      .CNT_W  (CNT_W)
   ) u_iter_counter (
      .clk (clk),
      .rst (rst),
      .clr ((r_state != ITER) || w_tc),
      .en  (r_state == ITER),
      .cnt (iter_cnt),
      .tc  (w_tc)
   );

   assign ld_in_en   = (r_state == LOAD_IN);
   assign sel_init   = (r_state == INIT);
   assign ld_iter_en = (r_state == INIT) || (r_state == ITER);
   assign ld_out_en  = (r_state == OUT);
   assign ready      = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign op_q       = r_op_q;

endmodule
`default_nettype wire
